pattern_sweep_capture: RTL and testbench

Hardware replacement for the exhaustive-vector testbench loop. The block sits directly upstream and downstream of a small combinational/sequential test_I* circuit under test. It drives every IN_W-bit pattern 0..2^IN_W-1 into the circuit in ascending order and samples the circuit's single-bit output after a settle time. Results are captured as a per-pattern response bitmap plus a MISR signature, so trojan-detection comparison needs only two register reads.

---
 rtl/pattern_sweep_capture.sv | 125 ++++++++++++
 tb/tb_pattern_sweep_capture.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module  : pattern_sweep_capture
// Brief   : Exhaustive ascending stimulus sweep with response bitmap + MISR.
// Revision: 1.0
// ============================================================================
module pattern_sweep_capture #(
    parameter int                IN_W     = 4,
    parameter int                SETTLE   = 1,
    parameter int                SIG_W    = 16,
    parameter logic [SIG_W-1:0]  SIG_POLY = 16'h1021,
    parameter logic [SIG_W-1:0]  SIG_SEED = 16'hFFFF
) (
    input  logic                    CK,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic [IN_W-1:0]         dut_in,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic [IN_W-1:0]         vec_idx,
    output logic [(1<<IN_W)-1:0]    resp_map,
    output logic [SIG_W-1:0]        signature
);

    localparam int              c_NPAT      = 1 << IN_W;
    localparam logic [IN_W-1:0] c_LAST      = IN_W'(c_NPAT - 1);
    localparam logic [3:0]      c_SETTLE_LD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [IN_W-1:0]     r_idx;
    logic                r_busy;
    logic                r_done;
    logic [c_NPAT-1:0]   r_map;
    logic [SIG_W-1:0]    r_sig;
    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [SIG_W-1:0]    w_sig_next;

    // Assertion propagates immediately; release is retimed through two flops.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? SIG_POLY : {SIG_W{1'b0}})
                      ^ {{(SIG_W-1){1'b0}}, dut_out};

    always_ff @(posedge CK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_map   <= '0;
            r_sig   <= '0;
        end else if (abort) begin
            // Partial results stay visible for post-mortem inspection.
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_map   <= '0;
                        r_sig   <= SIG_SEED;
                        r_idx   <= '0;
                        r_cnt   <= c_SETTLE_LD;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_map[r_idx] <= dut_out;
                    r_sig        <= w_sig_next;
                    if (r_idx == c_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_cnt   <= c_SETTLE_LD;
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dut_in    = r_idx;
    assign vec_idx   = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign resp_map  = r_map;
    assign signature = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_pattern_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_pattern_sweep_capture
// Brief   : Randomised sweeps of two DUT instances (SETTLE=1 comb, SETTLE=3 reg).
// Revision: 1.0
// ============================================================================
module tb_pattern_sweep_capture;

    logic        CK = 1'b0;
    logic        ck_en = 1'b1;
    logic        reset = 1'b0;
    logic        start0 = 1'b0, abort0 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
    logic [3:0]  dut_in0, vec0, dut_in3, vec3;
    logic        busy0, done0, busy3, done3;
    logic [15:0] map0, sig0, map3, sig3;
    logic [15:0] tt0 = 16'h0, tt3 = 16'h0;
    logic        dout0;
    logic        dout3 = 1'b0;

    int checks = 0;
    int failures = 0;
    int sel = 0;

    logic [3:0]  m_dut_in, m_vec;
    logic        m_busy, m_done;
    logic [15:0] m_map, m_sig;

    always begin
        #5;
        if (ck_en) CK = ~CK;
    end

    // Circuit under test models: truth-table lookup, direct or one-cycle registered.
    assign dout0 = tt0[dut_in0];
    always @(posedge CK) dout3 <= tt3[dut_in3];

    assign m_dut_in = (sel != 0) ? dut_in3 : dut_in0;
    assign m_vec    = (sel != 0) ? vec3    : vec0;
    assign m_busy   = (sel != 0) ? busy3   : busy0;
    assign m_done   = (sel != 0) ? done3   : done0;
    assign m_map    = (sel != 0) ? map3    : map0;
    assign m_sig    = (sel != 0) ? sig3    : sig0;

    pattern_sweep_capture u_dut0 (
        .CK(CK), .reset(reset), .start(start0), .abort(abort0),
        .dut_in(dut_in0), .dut_out(dout0), .busy(busy0), .done(done0),
        .vec_idx(vec0), .resp_map(map0), .signature(sig0)
    );

    pattern_sweep_capture #(.SETTLE(3)) u_dut3 (
        .CK(CK), .reset(reset), .start(start3), .abort(abort3),
        .dut_in(dut_in3), .dut_out(dout3), .busy(busy3), .done(done3),
        .vec_idx(vec3), .resp_map(map3), .signature(sig3)
    );

    // CRC-style signature of the first n responses, pattern 0 first.
    function automatic logic [15:0] model_sig(input logic [15:0] tt, input int n);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, tt[k]};
        end
        return s;
    endfunction

    task automatic pulse_start();
        if (sel != 0) start3 = 1'b1; else start0 = 1'b1;
        @(posedge CK); #1;
        start0 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic run_sweep(input int s, input logic [15:0] tt, input int settle);
        int n;
        int bad;
        int e;
        sel = s;
        if (s != 0) tt3 = tt; else tt0 = tt;
        pulse_start();
        checks++;
        if ({m_busy, m_done, m_dut_in, m_map, m_sig} !== {1'b1, 1'b0, 4'h0, 16'h0, 16'hFFFF}) begin
            failures++;
            $display("FAIL start_clear inst=%0d busy=%b done=%b dut_in=%h map=%h sig=%h exp 1 0 0 0000 ffff",
                     s, m_busy, m_done, m_dut_in, m_map, m_sig);
        end
        n = 0;
        bad = 0;
        while (!m_done && n < 400) begin
            @(posedge CK); #1;
            n++;
            e = n / (settle + 1);
            if (e > 15) e = 15;
            if (m_dut_in !== 4'(e) || m_vec !== 4'(e)) bad++;
        end
        checks++;
        if (n != 16 * (settle + 1)) begin
            failures++;
            $display("FAIL done_latency inst=%0d edges=%0d exp=%0d", s, n, 16 * (settle + 1));
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL dut_in_trace inst=%0d bad_edges=%0d exp=0", s, bad);
        end
        checks++;
        if (m_map !== tt) begin
            failures++;
            $display("FAIL resp_map inst=%0d got=%h exp=%h", s, m_map, tt);
        end
        checks++;
        if (m_sig !== model_sig(tt, 16)) begin
            failures++;
            $display("FAIL signature inst=%0d got=%h exp=%h", s, m_sig, model_sig(tt, 16));
        end
        checks++;
        if (m_busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_done inst=%0d got=%b exp=0", s, m_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        checks++;
        if ({busy0, done0, dut_in0, vec0, map0, sig0, busy3, done3, dut_in3, vec3, map3, sig3} !== '0) begin
            failures++;
            $display("FAIL reset_values got busy=%b done=%b dut_in=%h map=%h sig=%h exp all zero",
                     busy0, done0, dut_in0, map0, sig0);
        end
        reset = 1'b1;
        repeat (4) @(posedge CK);
        #1;
        checks++;
        if ({busy0, done0, vec0, busy3, done3, vec3} !== '0) begin
            failures++;
            $display("FAIL idle_after_release busy=%b done=%b vec=%h exp 0 0 0", busy0, done0, vec0);
        end
    endtask

    task automatic test_and_lsb();
        run_sweep(0, 16'h8000, 1);
        run_sweep(0, 16'hAAAA, 1);
    endtask

    task automatic test_no_wrap();
        repeat (10) @(posedge CK);
        #1;
        checks++;
        if ({done0, busy0, vec0, dut_in0} !== {1'b1, 1'b0, 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL no_wrap done=%b busy=%b vec=%h dut_in=%h exp 1 0 f f", done0, busy0, vec0, dut_in0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) run_sweep(0, 16'($urandom), 1);
    endtask

    task automatic test_settle3();
        run_sweep(1, 16'h8000, 3);
        run_sweep(1, 16'($urandom), 3);
    endtask

    task automatic test_start_while_busy();
        logic [15:0] tt;
        int n;
        tt = 16'($urandom);
        sel = 0;
        tt0 = tt;
        pulse_start();
        n = 0;
        while (vec0 !== 4'd5 && n < 200) begin
            @(posedge CK); #1;
            n++;
        end
        start0 = 1'b1;
        @(posedge CK); #1;
        start0 = 1'b0;
        n++;
        checks++;
        if ({busy0, vec0} !== {1'b1, 4'd5}) begin
            failures++;
            $display("FAIL start_ignored busy=%b vec=%h exp 1 5", busy0, vec0);
        end
        while (!done0 && n < 400) begin
            @(posedge CK); #1;
            n++;
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL restart_latency edges=%0d exp=32", n);
        end
        checks++;
        if ({map0, sig0} !== {tt, model_sig(tt, 16)}) begin
            failures++;
            $display("FAIL restart_results map=%h sig=%h exp %h %h", map0, sig0, tt, model_sig(tt, 16));
        end
    endtask

    task automatic test_abort_start_same();
        start0 = 1'b1;
        abort0 = 1'b1;
        @(posedge CK); #1;
        start0 = 1'b0;
        abort0 = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        checks++;
        if ({busy0, done0, vec0} !== {1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL abort_beats_start busy=%b done=%b vec=%h exp 0 0 0", busy0, done0, vec0);
        end
    endtask

    task automatic test_abort();
        logic [15:0] tt;
        int n;
        tt = 16'($urandom);
        sel = 0;
        tt0 = tt;
        pulse_start();
        n = 0;
        while (vec0 !== 4'd9 && n < 200) begin
            @(posedge CK); #1;
            n++;
        end
        abort0 = 1'b1;
        @(posedge CK); #1;
        abort0 = 1'b0;
        checks++;
        if ({busy0, done0, dut_in0, vec0} !== '0) begin
            failures++;
            $display("FAIL abort_state busy=%b done=%b dut_in=%h vec=%h exp 0 0 0 0", busy0, done0, dut_in0, vec0);
        end
        checks++;
        if ({map0, sig0} !== {tt & 16'h01FF, model_sig(tt, 9)}) begin
            failures++;
            $display("FAIL abort_partial map=%h sig=%h exp %h %h", map0, sig0, tt & 16'h01FF, model_sig(tt, 9));
        end
        repeat (5) @(posedge CK);
        #1;
        checks++;
        if ({busy0, vec0} !== '0) begin
            failures++;
            $display("FAIL abort_stays_idle busy=%b vec=%h exp 0 0", busy0, vec0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        sel = 0;
        tt0 = 16'($urandom);
        pulse_start();
        n = 0;
        while (vec0 !== 4'd7 && n < 200) begin
            @(posedge CK); #1;
            n++;
        end
        @(negedge CK);
        ck_en = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, dut_in0, vec0, map0, sig0} !== '0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b dut_in=%h vec=%h map=%h sig=%h exp all zero",
                     busy0, done0, dut_in0, vec0, map0, sig0);
        end
        #10;
        reset = 1'b1;
        #2;
        ck_en = 1'b1;
        repeat (4) @(posedge CK);
        #1;
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL no_auto_resume busy=%b exp 0", busy0);
        end
        run_sweep(0, 16'($urandom), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_and_lsb();
        test_no_wrap();
        test_random();
        test_settle3();
        test_start_while_busy();
        test_abort_start_same();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
